// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the shared data-memory port.
// Master 0 is the CPU load/store path and master 1 is the UART receive DMA.
// One single-word transaction at a time runs IDLE -> ACCESS -> RESP. The read
// data is registered and returned alongside a one-cycle ack.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Without it, m0 always wins a tie.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_gnt_id;
    logic              r_last_grant;
    logic              w_pick_m1;
    logic              w_load_cmd;
    logic              w_capture;
    logic              w_resp;

`ifdef ARB_ROUND_ROBIN_EN
    // Winner select: a lone requester wins; on a tie the master not served last wins
    always_comb begin
        w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);
    end
`else
    // Winner select: fixed priority, m0 wins every tie
    always_comb begin
        w_pick_m1 = m1_req & ~m0_req;
    end

    // last_grant is kept for parity with the round-robin build but nothing reads it here
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
`endif

    // State register; reset drops any in-flight transaction without an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; ack, mem_we and busy all come from the state alone
    always_comb begin
        w_state_next = r_state;
        w_load_cmd   = 1'b0;
        w_capture    = 1'b0;
        w_resp       = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b1;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (m0_req || m1_req) begin
                    w_load_cmd   = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we       = r_cmd_we;
                w_capture    = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                m0_ack       = ~r_gnt_id;
                m1_ack       = r_gnt_id;
                w_resp       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch in IDLE, read capture in ACCESS, grant history in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_rdata      <= '0;
            r_gnt_id     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_load_cmd) begin
                r_gnt_id    <= w_pick_m1;
                r_cmd_we    <= w_pick_m1 ? m1_we    : m0_we;
                r_cmd_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
                r_cmd_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
            if (w_resp) begin
                r_last_grant <= r_gnt_id;
            end
        end
    end

    // The memory port always shows the command registers.
    // Return data is gated so that a master without an ack sees zero.
    always_comb begin
        mem_addr  = r_cmd_addr;
        mem_wdata = r_cmd_wdata;
        m0_rdata  = m0_ack ? r_rdata : '0;
        m1_rdata  = m1_ack ? r_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized two-master run
// checked against a transaction-level reference model.
// The tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [15:0] mem_addr;
    logic        mem_we, busy;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // Memory model: read is combinational and write happens on the clock edge
    logic [31:0] env_mem [0:65535];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
    end

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit so that a stuck run still stops
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Runs one transaction from IDLE. It returns the ack latency in cycles after
    // req is driven (-1 on timeout), mem_we activity, and acks seen by the other master.
    task automatic run_single(input bit m, input bit we, input logic [15:0] a,
                              input logic [31:0] d, output logic [31:0] rd,
                              output int lat, output int we_cnt, output int we_at,
                              output int other_acks);
        rd = '0; lat = -1; we_cnt = 0; we_at = -1; other_acks = 0;
        if (!m) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        else    begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (mem_we) begin we_cnt++; we_at = k; end
            if (m ? m0_ack : m1_ack) other_acks++;
            if (m ? m1_ack : m0_ack) begin
                lat = k;
                rd  = m ? m1_rdata : m0_rdata;
            end
        end
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        if (mem_we) we_cnt++;
        if (m0_ack || m1_ack) other_acks++;
    endtask

    task automatic test_reset;
        int acks, wes;
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({m0_ack, m1_ack, m0_rdata, m1_rdata, mem_addr, mem_we, mem_wdata, busy} !== '0) begin
            bad++; $display("FAIL reset_outputs: got nonzero outputs busy=%0b mem_addr=%h, want all 0", busy, mem_addr);
        end
        rst_n = 1'b1;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0050; m0_wdata = 32'h11223344;
        @(posedge clk); #1;
        total++;
        if (mem_we !== 1'b1) begin
            bad++; $display("FAIL reset_access_setup: mem_we=%0b, want 1", mem_we);
        end
        #3;
        rst_n = 1'b0;
        m0_req = 0;
        #1;
        total++;
        if ({m0_ack, m1_ack, m0_rdata, m1_rdata, mem_addr, mem_we, mem_wdata, busy} !== '0) begin
            bad++; $display("FAIL reset_async: busy=%0b mem_we=%0b mem_addr=%h mem_wdata=%h, want all 0",
                            busy, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0; wes = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) acks++;
            if (mem_we) wes++;
        end
        total++;
        if (acks != 0 || wes != 0) begin
            bad++; $display("FAIL reset_no_ack: acks=%0d mem_we_pulses=%0d, want 0 and 0", acks, wes);
        end
        total++;
        if (env_mem[16'h0050] !== 32'hC0DE0050) begin
            bad++; $display("FAIL reset_no_write: mem[0050]=%h, want c0de0050", env_mem[16'h0050]);
        end
    endtask

    task automatic test_m0_store_load;
        logic [31:0] rd;
        int lat, wc, wat, oth;
        run_single(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, rd, lat, wc, wat, oth);
        total++;
        if (lat != 2 || wc != 1 || wat != 1 || oth != 0) begin
            bad++; $display("FAIL m0_store: lat=%0d we_pulses=%0d we_cycle=%0d m1_acks=%0d, want 2 1 1 0",
                            lat, wc, wat, oth);
        end
        total++;
        if (env_mem[16'h0010] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL m0_store_mem: mem[0010]=%h, want deadbeef", env_mem[16'h0010]);
        end
        run_single(1'b0, 1'b0, 16'h0010, 32'h0, rd, lat, wc, wat, oth);
        total++;
        if (lat != 2 || rd !== 32'hDEADBEEF || wc != 0 || oth != 0) begin
            bad++; $display("FAIL m0_load: lat=%0d rdata=%h we_pulses=%0d, want 2 deadbeef 0", lat, rd, wc);
        end
    endtask

    task automatic test_m1_load;
        logic [31:0] rd;
        int lat, wc, wat, oth;
        env_mem[16'h0020] <= 32'h000000A5;
        @(posedge clk); #1;
        run_single(1'b1, 1'b0, 16'h0020, 32'h0, rd, lat, wc, wat, oth);
        total++;
        if (lat != 2 || rd !== 32'h000000A5 || oth != 0 || wc != 0) begin
            bad++; $display("FAIL m1_load: lat=%0d rdata=%h m0_acks=%0d we_pulses=%0d, want 2 000000a5 0 0",
                            lat, rd, oth, wc);
        end
    endtask

    task automatic test_tie;
        int ids[4];
        int cyc[4];
        int n, both, j;
        logic [3:0] got_ids, want_ids;
        apply_reset();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0020;
        n = 0; both = 0;
        for (int k = 1; k <= 20 && n < 4; k++) begin
            @(posedge clk); #1;
            if (m0_ack && m1_ack) both++;
            if (m0_ack) begin ids[n] = 0; cyc[n] = k; n++; end
            else if (m1_ack) begin ids[n] = 1; cyc[n] = k; n++; end
        end
        // Release m0 in the cycle of the fourth ack; m1 keeps requesting
        m0_req = 0;
        total++;
        if (n != 4 || both != 0) begin
            bad++; $display("FAIL tie_count: acks=%0d simultaneous=%0d, want 4 and 0", n, both);
        end else begin
            got_ids = {ids[0][0], ids[1][0], ids[2][0], ids[3][0]};
            want_ids = RR ? 4'b0101 : 4'b0000;
            total++;
            if (got_ids !== want_ids) begin
                bad++; $display("FAIL tie_order: masters=%b, want %b", got_ids, want_ids);
            end
            total++;
            if (cyc[0] != 2 || cyc[1] - cyc[0] != 3 || cyc[2] - cyc[1] != 3 || cyc[3] - cyc[2] != 3) begin
                bad++; $display("FAIL tie_spacing: ack cycles %0d %0d %0d %0d, want 2 5 8 11",
                                cyc[0], cyc[1], cyc[2], cyc[3]);
            end
        end
        // IDLE comes one cycle later, then grant, then ack
        j = -1;
        for (int k = 1; k <= 8 && j < 0; k++) begin
            @(posedge clk); #1;
            if (m1_ack) j = k;
        end
        total++;
        if (j != 3) begin
            bad++; $display("FAIL tie_m1_after_drop: m1_ack at %0d cycles, want 3", j);
        end
        m1_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_addr_change;
        logic [31:0] rd;
        int lat;
        env_mem[16'h0030] <= 32'h12345678;
        env_mem[16'h0040] <= 32'h0BADF00D;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0030; m0_wdata = 32'h0;
        @(posedge clk); #1;
        m0_addr = 16'h0040;
        total++;
        if (mem_addr !== 16'h0030) begin
            bad++; $display("FAIL addr_change_access: mem_addr=%h, want 0030", mem_addr);
        end
        lat = -1; rd = '0;
        for (int k = 1; k <= 5 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (m0_ack) begin lat = k; rd = m0_rdata; end
        end
        m0_req = 0;
        total++;
        if (lat != 1 || rd !== 32'h12345678 || mem_addr !== 16'h0030) begin
            bad++; $display("FAIL addr_change_load: lat=%0d rdata=%h mem_addr=%h, want 1 12345678 0030",
                            lat, rd, mem_addr);
        end
        @(posedge clk); #1;
    endtask

    // Randomized run. The reference model treats each grant as an atomic transaction:
    // the grant at edge g shows mem_we in cycle g, the ack in cycle g+1, and the next
    // sampling edge at g+3.
    task automatic test_random;
        logic [31:0] mm [16];
        bit          pend0, pend1, last, win, ewe, exp0, exp1;
        logic [15:0] eaddr;
        logic [31:0] ewd, erd;
        int          g, free_at;
        apply_reset();
        for (int i = 0; i < 16; i++) mm[i] = {16'hC0DE, 16'h0080 + 16'(i)};
        pend0 = 0; pend1 = 0; last = 1; win = 0; ewe = 0;
        eaddr = '0; ewd = '0; erd = '0; g = -10; free_at = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c >= free_at && (m0_req || m1_req)) begin
                if (m0_req && m1_req) win = RR ? ~last : 1'b0;
                else                  win = m1_req;
                ewe   = win ? m1_we    : m0_we;
                eaddr = win ? m1_addr  : m0_addr;
                ewd   = win ? m1_wdata : m0_wdata;
                erd   = mm[eaddr[3:0]];
                if (ewe) mm[eaddr[3:0]] = ewd;
                last = win; g = c; free_at = c + 3;
            end
            exp0 = (c == g + 1) && !win;
            exp1 = (c == g + 1) && win;
            total++;
            if (mem_we !== ((c == g) ? ewe : 1'b0)) begin
                bad++; $display("FAIL rand_mem_we c=%0d: got %0b want %0b", c, mem_we, (c == g) ? ewe : 1'b0);
            end
            if (c == g) begin
                total++;
                if (mem_addr !== eaddr || (ewe && mem_wdata !== ewd)) begin
                    bad++; $display("FAIL rand_cmd c=%0d: addr=%h wdata=%h want %h %h", c, mem_addr, mem_wdata, eaddr, ewd);
                end
            end
            total++;
            if (busy !== ((c == g) || (c == g + 1))) begin
                bad++; $display("FAIL rand_busy c=%0d: got %0b", c, busy);
            end
            total++;
            if ({m0_ack, m1_ack} !== {exp0, exp1}) begin
                bad++; $display("FAIL rand_ack c=%0d: got m0=%0b m1=%0b want m0=%0b m1=%0b", c, m0_ack, m1_ack, exp0, exp1);
            end
            if (!(exp0 && ewe)) begin
                total++;
                if (m0_rdata !== (exp0 ? erd : 32'h0)) begin
                    bad++; $display("FAIL rand_m0_rdata c=%0d: got %h want %h", c, m0_rdata, exp0 ? erd : 32'h0);
                end
            end
            if (!(exp1 && ewe)) begin
                total++;
                if (m1_rdata !== (exp1 ? erd : 32'h0)) begin
                    bad++; $display("FAIL rand_m1_rdata c=%0d: got %h want %h", c, m1_rdata, exp1 ? erd : 32'h0);
                end
            end
            if (exp0) pend0 = 0;
            if (exp1) pend1 = 0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1; m0_we = 1'($urandom_range(0, 1));
                m0_addr = 16'h0080 + 16'($urandom_range(0, 15)); m0_wdata = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; m1_we = 1'($urandom_range(0, 1));
                m1_addr = 16'h0080 + 16'($urandom_range(0, 15)); m1_wdata = $urandom;
            end
            m0_req = pend0;
            m1_req = pend1;
        end
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 65536; i++) env_mem[i] <= {16'hC0DE, 16'(i)};
        test_reset();
        test_m0_store_load();
        test_m1_load();
        test_tie();
        test_addr_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
